fifo_wr_packer: RTL and testbench

Upstream write-side stage for the synchronous FIFO. Accepts narrow IN_W-bit beats on a valid/ready handshake and packs N = OUT_W/IN_W beats into one OUT_W-bit word. On `i_last` it flushes a partial word with zero padding. It drives the FIFO write port (`o_wren`/`o_wrdata`) and stalls its source from the FIFO `i_full` flag, so no write is ever issued into a full FIFO.

---
 rtl/fifo_wr_packer.sv | 77 +++++++
 tb/tb_fifo_wr_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs IN_W-bit beats into OUT_W-bit FIFO words, zero-padding on i_last,
// with a one-word hold register that stalls the source while the FIFO is full.
module fifo_wr_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_last,
    output logic             o_ready,
    output logic             o_wren,
    output logic [OUT_W-1:0] o_wrdata,
    input  logic             i_full,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [CNT_W-1:0] o_pad_cnt
);
    localparam int N     = OUT_W / IN_W;
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_idx;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_hold_data;
    logic             r_hold_v;
    logic             r_hold_pad;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_pad_cnt;
    logic             w_acc;
    logic             w_last_lane;
    logic             w_done;
    logic [OUT_W-1:0] w_word;

    assign o_ready     = !rst && (!r_hold_v || !i_full);
    assign o_wren      = !rst && r_hold_v && !i_full;
    assign o_wrdata    = r_hold_data;
    assign o_word_cnt  = r_word_cnt;
    assign o_pad_cnt   = r_pad_cnt;
    assign w_acc       = i_valid && o_ready;
    assign w_last_lane = r_idx == IDX_W'(N - 1);
    assign w_done      = w_acc && (w_last_lane || i_last);

    // Lanes above idx are already zero in the accumulator, which gives the padding for free.
    always_comb begin
        w_word = r_acc;
        for (int k = 0; k < N; k++)
            if (IDX_W'(k) == r_idx) w_word[k*IN_W +: IN_W] = i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_hold_data <= '0;
            r_hold_v    <= 1'b0;
            r_hold_pad  <= 1'b0;
            r_word_cnt  <= '0;
            r_pad_cnt   <= '0;
        end else begin
            if (w_done) begin
                r_hold_data <= w_word;
                r_hold_pad  <= !w_last_lane;
                r_acc       <= '0;
                r_idx       <= '0;
            end else if (w_acc) begin
                r_acc <= w_word;
                r_idx <= r_idx + 1'b1;
            end
            r_hold_v <= w_done ? 1'b1 : (o_wren ? 1'b0 : r_hold_v);
            if (o_wren) begin
                r_word_cnt <= r_word_cnt + 1'b1;
                r_pad_cnt  <= r_pad_cnt + CNT_W'(r_hold_pad);
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: scoreboard bench; a lane model queues expected words as beats are
// accepted and a negedge monitor pops and compares them against each FIFO write.
module tb_fifo_wr_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic [31:0]  i_data = '0;
    logic         i_last = 1'b0;
    logic         i_full = 1'b0;
    logic         o_ready;
    logic         o_wren;
    logic [127:0] o_wrdata;
    logic [3:0]   o_word_cnt;
    logic [3:0]   o_pad_cnt;

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int run = 0;
    int max_run = 0;
    int n0;
    int m_idx = 0;
    logic [127:0] m_acc = '0;
    logic [127:0] last_wr = '0;
    logic [127:0] hold_snap;
    logic [127:0] q[$];

    fifo_wr_packer #(.IN_W(32), .OUT_W(128), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
        .o_ready(o_ready), .o_wren(o_wren), .o_wrdata(o_wrdata), .i_full(i_full),
        .o_word_cnt(o_word_cnt), .o_pad_cnt(o_pad_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [31:0] d, input logic l);
        m_acc[m_idx*32 +: 32] = d;
        if (l || m_idx == 3) begin
            q.push_back(m_acc);
            m_acc = '0;
            m_idx = 0;
        end else m_idx++;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit ok = 0;
        i_valid = 1'b1;
        i_data = d;
        i_last = l;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = o_ready;
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        if (ok) model_accept(d, l);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_last = 1'b0;
        @(negedge clk);
        check("rst_ready", o_ready, 0);
        check("rst_wren", o_wren, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_idx = 0;
        m_acc = '0;
        q.delete();
    endtask

    always @(negedge clk) begin
        if (o_wren) begin
            n_wr++;
            run++;
            last_wr = o_wrdata;
            if (q.size() == 0) check("unexpected_wr", 1, 0);
            else check("wrdata", o_wrdata, q.pop_front());
        end else run = 0;
        if (run > max_run) max_run = run;
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_word_cnt", o_word_cnt, 0);
        check("rst_pad_cnt", o_pad_cnt, 0);
        check("rst_wrdata", o_wrdata, 0);
        @(posedge clk);
        #1;

        // full word, one write one cycle after the 4th beat
        n0 = n_wr;
        send(32'h11111111, 0);
        send(32'h22222222, 0);
        send(32'h33333333, 0);
        send(32'h44444444, 0);
        i_valid = 1'b0;
        @(negedge clk);
        check("full_latency", o_wren, 1);
        idle(3);
        check("full_nwr", n_wr - n0, 1);
        check("full_word", last_wr, 128'h44444444_33333333_22222222_11111111);
        check("full_word_cnt", o_word_cnt, 1);
        check("full_pad_cnt", o_pad_cnt, 0);

        // partial flush then a full word starting at lane 0
        send(32'hA, 0);
        send(32'hB, 1);
        idle(3);
        check("part_word", last_wr, 128'h00000000_00000000_0000000B_0000000A);
        check("part_pad_cnt", o_pad_cnt, 1);
        check("part_word_cnt", o_word_cnt, 2);
        send(32'hC, 0);
        send(32'hD, 0);
        send(32'hE, 0);
        send(32'hF, 0);
        idle(3);
        check("after_part", last_wr, 128'h0000000F_0000000E_0000000D_0000000C);

        // back-pressure: hold a word with i_full high while a beat waits
        i_full = 1'b1;
        send(32'h1, 0);
        send(32'h2, 0);
        send(32'h3, 0);
        send(32'h4, 0);
        i_data = 32'h55;
        hold_snap = 128'h00000004_00000003_00000002_00000001;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", o_ready, 0);
            check("bp_wren", o_wren, 0);
            check("bp_hold", o_wrdata, hold_snap);
        end
        @(posedge clk);
        #1;
        i_full = 1'b0;
        @(negedge clk);
        check("bp_release_wren", o_wren, 1);
        check("bp_release_ready", o_ready, 1);
        @(posedge clk);
        model_accept(32'h55, 0);
        #1;
        send(32'h66, 0);
        send(32'h77, 0);
        send(32'h88, 1);
        idle(3);
        check("bp_next", last_wr, 128'h00000088_00000077_00000066_00000055);

        // back-to-back single-lane words
        do_reset();
        n0 = n_wr;
        max_run = 0;
        for (int k = 0; k < 8; k++) send(32'h100 + k, 1);
        idle(3);
        check("b2b_nwr", n_wr - n0, 8);
        check("b2b_run", max_run, 8);
        check("b2b_pad_cnt", o_pad_cnt, 8);
        check("b2b_word_cnt", o_word_cnt, 8);

        // reset in the middle of a word discards it
        do_reset();
        send(32'hDEAD0001, 0);
        send(32'hDEAD0002, 0);
        do_reset();
        n0 = n_wr;
        send(32'h5, 0);
        send(32'h6, 0);
        send(32'h7, 0);
        send(32'h8, 0);
        idle(3);
        check("mid_nwr", n_wr - n0, 1);
        check("mid_word", last_wr, 128'h00000008_00000007_00000006_00000005);
        check("mid_word_cnt", o_word_cnt, 1);
        check("mid_pad_cnt", o_pad_cnt, 0);

        // counter wrap at CNT_W=4
        do_reset();
        for (int w = 0; w < 17; w++)
            for (int b = 0; b < 4; b++) send(32'(w * 16 + b), 0);
        idle(3);
        check("wrap_word_cnt", o_word_cnt, 1);
        check("wrap_pad_cnt", o_pad_cnt, 0);
        check("sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
